// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register-file debug dump engine; define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] cnt_inc;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  // xor_q accumulates every register word; reg_last_q marks the final register
  // word so the checksum word can follow it; csum_q is set while the checksum
  // word itself is on the stream.
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              reg_last_q, reg_last_d;
  logic              csum_q, csum_d;
`endif

  assign rd_req    = (state_q == S_READ);
  assign rd_addr   = cnt_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = oaddr_q;
  assign out_last  = last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // Address counter successor, wrapping at the register count rather than the bit width.
  always_comb begin
    cnt_inc = (cnt_q == ADDR_MAX) ? '0 : cnt_q + 1'b1;
  end

  // Next-state and datapath: one read-port grant per word, then hold the word until accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    xor_d      = xor_q;
    reg_last_d = reg_last_q;
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = first_addr;
          end_d   = last_addr;
          state_d = S_READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          xor_d  = '0;
          csum_d = 1'b0;
`endif
        end
      end
      S_READ: begin
        if (rd_gnt) begin
          data_d  = rd_data;
          oaddr_d = cnt_q;
          valid_d = 1'b1;
          state_d = S_SEND;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          last_d     = 1'b0;
          reg_last_d = (cnt_q == end_q);
          xor_d      = xor_q ^ rd_data;
`else
          last_d = (cnt_q == end_q);
`endif
        end
      end
      S_SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          if (csum_q) begin
            csum_d  = 1'b0;
            state_d = S_DONE;
          end else if (reg_last_q) begin
            // Checksum word goes straight out without another read-port request.
            data_d  = xor_q;
            oaddr_d = end_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
            csum_d  = 1'b1;
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_READ;
          end
`else
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_READ;
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort overrides whatever the state machine decided this cycle.
    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_d = 1'b0;
`endif
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      end_q   <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      xor_q      <= '0;
      reg_last_q <= 1'b0;
      csum_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      xor_q      <= xor_d;
      reg_last_q <= reg_last_d;
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - randomized self-checking bench for regfile_dump
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset, start, abort, rd_gnt, out_ready;
  logic [4:0]  first_addr, last_addr, rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        rd_req, out_valid, out_last, busy, done;
  logic [31:0] regs [32];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } word_t;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One dump: builds the expected word list from the range rule, then drives
  // grant/ready and checks every accepted word, stalls, latency and abort.
  task automatic run_dump(input int f, input int l, input int gnt_pct, input int rdy_pct,
                          input int gnt_off, input int rdy_off, input int abort_word,
                          input bit extra_start, input int exp_cycles);
    word_t       exp_q[$];
    word_t       w;
    int          n, got, cyc;
    logic [31:0] x;
    logic [37:0] held;
    bit          hold, abort_now, fin, pv, pg;
    exp_q.delete();
    x = 0;
    n = ((l - f) & 31) + 1;
    for (int i = 0; i < n; i++) begin
      w.a = 5'((f + i) % 32);
      w.d = regs[w.a];
      x = x ^ w.d;
      w.l = (i == n - 1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
      w.l = 1'b0;
`endif
      exp_q.push_back(w);
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    w.a = 5'(l);
    w.d = x;
    w.l = 1'b1;
    exp_q.push_back(w);
`endif
    @(posedge clk); #1;
    start = 1'b1; first_addr = 5'(f); last_addr = 5'(l);
    rd_gnt = 1'b0; out_ready = 1'b0; abort = 1'b0;
    got = 0; cyc = 0; hold = 0; abort_now = 0; fin = 0; pv = 0; pg = 0; held = '0;
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start = extra_start && (cyc == 3);
      if (extra_start && cyc == 3) first_addr = 5'(f + 5);
      abort = abort_now;
      rd_gnt = (cyc > gnt_off) && ($urandom_range(99) < gnt_pct);
      out_ready = (cyc > rdy_off) && (got != abort_word) && ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (abort) begin
        check("words_before_abort", got, abort_word);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", {out_valid, out_last, rd_req, busy, done}, 0);
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          @(negedge clk);
          check("no_done_after_abort", {done, busy}, 0);
        end
        fin = 1;
      end else begin
        if (cyc == 1) check("start_busy_rdreq", {busy, rd_req}, 2'b11);
        if (gnt_off > 0 && cyc == gnt_off) check("no_valid_before_gnt", out_valid, 0);
        if (out_valid && !pv) check("valid_follows_gnt", pg, 1);
        if (hold) check("stall_hold", {out_valid, out_last, out_addr, out_data}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (got < exp_q.size())
            check("word", {out_last, out_addr, out_data}, {exp_q[got].l, exp_q[got].a, exp_q[got].d});
          else
            check("extra_word", 1, 0);
          got++;
        end
        if (abort_word >= 0 && out_valid && got == abort_word) abort_now = 1;
        hold = out_valid && !out_ready;
        held = {out_last, out_addr, out_data};
        pv = out_valid;
        pg = rd_gnt && rd_req;
        if (done) begin
          check("word_count", got, exp_q.size());
          if (exp_cycles > 0) check("done_latency", cyc, exp_cycles);
          @(posedge clk); #1;
          @(negedge clk);
          check("idle_after_done", {busy, done, out_valid, rd_req}, 0);
          fin = 1;
        end
        if (!fin && cyc > 3000) begin
          check("timeout", 0, 1);
          fin = 1;
        end
      end
    end
    start = 1'b0; abort = 1'b0; rd_gnt = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    int full_cyc;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    full_cyc = 66;
`else
    full_cyc = 65;
`endif
    reset = 1'b0; start = 1'b0; abort = 1'b0; rd_gnt = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h1111_1111;
    #22;
    check("reset_outputs", {out_valid, out_last, out_data, out_addr, rd_req, rd_addr, busy, done}, 0);
    @(negedge clk);
    reset = 1'b1;

    run_dump(0, 31, 100, 100, 0, 0, -1, 0, full_cyc);
    run_dump(30, 1, 100, 100, 0, 0, -1, 0, 0);
    run_dump(7, 7, 100, 100, 0, 6, -1, 0, 0);
    run_dump(10, 14, 100, 100, 4, 0, -1, 1, 0);
    run_dump(3, 20, 100, 100, 0, 0, 2, 0, 0);

    // Reset asserted mid-dump clears outputs without waiting for a clock.
    @(posedge clk); #1;
    start = 1'b1; first_addr = 5'd4; last_addr = 5'd12; rd_gnt = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("reset_async", {out_valid, out_last, out_data, out_addr, rd_req, rd_addr, busy, done}, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_reset", {busy, done, out_valid, rd_req}, 0);
    end
    rd_gnt = 1'b0; out_ready = 1'b0;

    regs[1] = 32'hF0; regs[2] = 32'h0F; regs[3] = 32'hFF;
    run_dump(1, 3, 100, 100, 0, 0, -1, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump(int'($urandom_range(31)), int'($urandom_range(31)), 60, 60, 0, 0, -1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
